// File: rtl/ycbcr2rgb_if.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb_if -- pixel bus for the YCbCr-to-RGB converter.
//
// Carries the pipeline advance enable, the YCbCr pixel with its syncs and
// data enable on the input side, and the RGB pixel with its delayed syncs
// on the output side.
//   slave  : converter side (consumes ce/y/cb/cr/syncs, drives r/g/b/syncs)
//   master : source/sink side (the opposite directions)
// ---------------------------------------------------------------------------
interface ycbcr2rgb_if;
    logic       ce;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       hdmi_hs_in;
    logic       hdmi_vs_in;
    logic       de_in;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hdmi_hs_out;
    logic       hdmi_vs_out;
    logic       de_out;

    modport slave (
        input  ce, y, cb, cr, hdmi_hs_in, hdmi_vs_in, de_in,
        output r, g, b, hdmi_hs_out, hdmi_vs_out, de_out
    );

    modport master (
        output ce, y, cb, cr, hdmi_hs_in, hdmi_vs_in, de_in,
        input  r, g, b, hdmi_hs_out, hdmi_vs_out, de_out
    );
endinterface

// File: rtl/ycbcr2rgb.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb -- 4-stage full-range BT.601 (JPEG) YCbCr to RGB converter.
//
//   R = Y + 1.402*Cr'   G = Y - 0.344136*Cb' - 0.714136*Cr'   B = Y + 1.772*Cb'
//   with Cb' = cb-128, Cr' = cr-128, Q2.14 coefficients, round-half-up and
//   saturation to 0..255.
//
// Ports:
//   clk    pixel clock, rising edge
//   rst_n  asynchronous active-low reset, clears every stage
//   px     ycbcr2rgb_if.slave: ce (advance enable), y/cb/cr + hs/vs/de in,
//          r/g/b + hs/vs/de out (4 ce-qualified edges of latency)
//
// Build option:
//   YCBCR2RGB_BLANK_EN  when defined, r/g/b are forced to 0 for pixels whose
//                       data enable is low.
// ---------------------------------------------------------------------------
module ycbcr2rgb (
    input  logic           clk,
    input  logic           rst_n,
    ycbcr2rgb_if.slave     px
);

    // Q2.14 coefficients, kept 25 bits wide so products need no extension.
    localparam logic signed [24:0] K_R_CR = 25'sd22970; // 1.402
    localparam logic signed [24:0] K_G_CB = 25'sd5638;  // 0.344136
    localparam logic signed [24:0] K_G_CR = 25'sd11700; // 0.714136
    localparam logic signed [24:0] K_B_CB = 25'sd29032; // 1.772
    localparam logic signed [26:0] RND    = 27'sd8192;  // 0.5 LSB after >>>14

    // S1
    logic        [7:0]  y1_q,  y1_d;
    logic signed [8:0]  cb1_q, cb1_d;
    logic signed [8:0]  cr1_q, cr1_d;
    // S2
    logic        [21:0] ylin2_q, ylin2_d;
    logic signed [24:0] pr2_q,  pr2_d;
    logic signed [24:0] pgb2_q, pgb2_d;
    logic signed [24:0] pgr2_q, pgr2_d;
    logic signed [24:0] pb2_q,  pb2_d;
    // S3
    logic signed [26:0] sr3_q, sr3_d;
    logic signed [26:0] sg3_q, sg3_d;
    logic signed [26:0] sb3_q, sb3_d;
    // S4
    logic        [7:0]  r4_q, r4_d;
    logic        [7:0]  g4_q, g4_d;
    logic        [7:0]  b4_q, b4_d;
    // {hs,vs,de} per stage; index k holds the bits aligned with stage k+1
    logic [3:0][2:0]    sync_q, sync_d;

    logic signed [24:0] cbx, crx;
    logic signed [26:0] yx, prx, pgbx, pgrx, pbx;

    function automatic logic [7:0] sat8(input logic signed [26:0] s);
        logic signed [26:0] t;
        t = s >>> 14;
        if (t < 27'sd0)
            return 8'd0;
        else if (t > 27'sd255)
            return 8'hff;
        return t[7:0];
    endfunction

    always_comb begin
        // defaults: every stage holds when ce is low
        y1_d    = y1_q;
        cb1_d   = cb1_q;
        cr1_d   = cr1_q;
        ylin2_d = ylin2_q;
        pr2_d   = pr2_q;
        pgb2_d  = pgb2_q;
        pgr2_d  = pgr2_q;
        pb2_d   = pb2_q;
        sr3_d   = sr3_q;
        sg3_d   = sg3_q;
        sb3_d   = sb3_q;
        r4_d    = r4_q;
        g4_d    = g4_q;
        b4_d    = b4_q;
        sync_d  = sync_q;

        // sized casts of signed values sign-extend
        cbx  = 25'(cb1_q);
        crx  = 25'(cr1_q);
        yx   = {5'd0, ylin2_q};
        prx  = 27'(pr2_q);
        pgbx = 27'(pgb2_q);
        pgrx = 27'(pgr2_q);
        pbx  = 27'(pb2_q);

        if (px.ce) begin
            // S1: remove chroma offset (mod-512 arithmetic gives -128..127)
            y1_d  = px.y;
            cb1_d = $signed({1'b0, px.cb}) - 9'sd128;
            cr1_d = $signed({1'b0, px.cr}) - 9'sd128;

            // S2: products stay positive-coefficient; G subtracts in S3
            ylin2_d = {y1_q, 14'd0};
            pr2_d   = crx * K_R_CR;
            pgb2_d  = cbx * K_G_CB;
            pgr2_d  = crx * K_G_CR;
            pb2_d   = cbx * K_B_CB;

            // S3
            sr3_d = yx + prx + RND;
            sg3_d = yx - pgbx - pgrx + RND;
            sb3_d = yx + pbx + RND;

            // S4
            r4_d = sat8(sr3_q);
            g4_d = sat8(sg3_q);
            b4_d = sat8(sb3_q);
`ifdef YCBCR2RGB_BLANK_EN
            if (!sync_q[2][0]) begin
                r4_d = 8'd0;
                g4_d = 8'd0;
                b4_d = 8'd0;
            end
`else
`endif

            sync_d = {sync_q[2:0], {px.hdmi_hs_in, px.hdmi_vs_in, px.de_in}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_q    <= '0;
            cb1_q   <= '0;
            cr1_q   <= '0;
            ylin2_q <= '0;
            pr2_q   <= '0;
            pgb2_q  <= '0;
            pgr2_q  <= '0;
            pb2_q   <= '0;
            sr3_q   <= '0;
            sg3_q   <= '0;
            sb3_q   <= '0;
            r4_q    <= '0;
            g4_q    <= '0;
            b4_q    <= '0;
            sync_q  <= '0;
        end else begin
            y1_q    <= y1_d;
            cb1_q   <= cb1_d;
            cr1_q   <= cr1_d;
            ylin2_q <= ylin2_d;
            pr2_q   <= pr2_d;
            pgb2_q  <= pgb2_d;
            pgr2_q  <= pgr2_d;
            pb2_q   <= pb2_d;
            sr3_q   <= sr3_d;
            sg3_q   <= sg3_d;
            sb3_q   <= sb3_d;
            r4_q    <= r4_d;
            g4_q    <= g4_d;
            b4_q    <= b4_d;
            sync_q  <= sync_d;
        end
    end

    assign px.r           = r4_q;
    assign px.g           = g4_q;
    assign px.b           = b4_q;
    assign px.hdmi_hs_out = sync_q[3][2];
    assign px.hdmi_vs_out = sync_q[3][1];
    assign px.de_out      = sync_q[3][0];

endmodule

// File: tb/tb_ycbcr2rgb.sv
// ---------------------------------------------------------------------------
// tb_ycbcr2rgb -- scoreboard bench for ycbcr2rgb.
// The driver pushes the expected RGB/sync tuple for every pixel sampled on a
// ce-high edge; the monitor pops one entry per ce-qualified edge once the
// pipeline has filled, expects zeros before that, and expects held outputs
// on ce-low edges.
// ---------------------------------------------------------------------------
module tb_ycbcr2rgb;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       hs, vs, de;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ycbcr2rgb_if vif();

    ycbcr2rgb dut (.clk(clk), .rst_n(rst_n), .px(vif));

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model (floating-point-free integer form) ---
    function automatic int clamp255(int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic exp_t model(int yv, int cbv, int crv, bit hs, bit vs, bit de);
        exp_t e;
        int cbp, crp, rr, gg, bb;
        cbp = cbv - 128;
        crp = crv - 128;
        // round-half-up of (Y*2^14 + coef*C') / 2^14, floor for negatives
        rr = (yv * 16384 + 22970 * crp + 8192) >>> 14;
        gg = (yv * 16384 - 5638 * cbp - 11700 * crp + 8192) >>> 14;
        bb = (yv * 16384 + 29032 * cbp + 8192) >>> 14;
        e.r = 8'(clamp255(rr));
        e.g = 8'(clamp255(gg));
        e.b = 8'(clamp255(bb));
`ifdef YCBCR2RGB_BLANK_EN
        if (!de) begin
            e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
        end
`else
`endif
        e.hs = hs; e.vs = vs; e.de = de;
        return e;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic drive(bit cev, int yv, int cbv, int crv, bit hs, bit vs, bit de, exp_t e);
        @(posedge clk);
        #1;
        vif.ce = cev;
        vif.y = 8'(yv); vif.cb = 8'(cbv); vif.cr = 8'(crv);
        vif.hdmi_hs_in = hs; vif.hdmi_vs_in = vs; vif.de_in = de;
        if (cev) exp_q.push_back(e);
    endtask

    task automatic send_model(bit cev, int yv, int cbv, int crv, bit hs, bit vs, bit de);
        drive(cev, yv, cbv, crv, hs, vs, de, model(yv, cbv, crv, hs, vs, de));
    endtask

    task automatic send_exp(int yv, int cbv, int crv, bit de, int er, int eg, int eb);
        exp_t e;
        e.r = 8'(er); e.g = 8'(eg); e.b = 8'(eb);
        e.hs = 1'b0; e.vs = 1'b0; e.de = de;
        drive(1'b1, yv, cbv, crv, 1'b0, 1'b0, de, e);
    endtask

    task automatic rand_stream(int n);
        for (int i = 0; i < n; i++)
            send_model(($urandom_range(99) < 70), $urandom_range(255), $urandom_range(255),
                       $urandom_range(255), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // ---------------- monitor ----------------
    bit   ce_edge;
    int   ce_cnt;
    exp_t prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_edge = 1'b0;
            ce_cnt  = 0;
        end else begin
            ce_edge = vif.ce;
            if (vif.ce) ce_cnt++;
        end
    end

    function automatic exp_t actual();
        exp_t a;
        a.r = vif.r; a.g = vif.g; a.b = vif.b;
        a.hs = vif.hdmi_hs_out; a.vs = vif.hdmi_vs_out; a.de = vif.de_out;
        return a;
    endfunction

    task automatic cmp(string name, exp_t a, exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got r=%0d g=%0d b=%0d hs=%0b vs=%0b de=%0b want r=%0d g=%0d b=%0d hs=%0b vs=%0b de=%0b",
                     name, a.r, a.g, a.b, a.hs, a.vs, a.de, e.r, e.g, e.b, e.hs, e.vs, e.de);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ce_cnt < 4) begin
                cmp("fill_zero", actual(), '0);
            end else if (ce_edge) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty got output with no expected pixel");
                end else begin
                    cmp("pixel", actual(), exp_q.pop_front());
                end
                prev = actual();
            end else begin
                cmp("hold", actual(), prev);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vif.ce = 1'b0; vif.y = '0; vif.cb = '0; vif.cr = '0;
        vif.hdmi_hs_in = 1'b0; vif.hdmi_vs_in = 1'b0; vif.de_in = 1'b0;
        #1;
        cmp("reset_state", actual(), '0);
        #22 rst_n = 1'b1;

        // directed corner pixels
        send_exp(128, 128, 128, 1'b1, 128, 128, 128);   // neutral
        send_exp(76,  85,  255, 1'b1, 254, 0,   0);     // G rounds 1718+8192 down to 0
        send_exp(255, 128, 255, 1'b1, 255, 164, 255);   // R clamps high
        send_exp(0,   0,   128, 1'b1, 0,   44,  0);     // B clamps low; G = -0.344*-128
`ifdef YCBCR2RGB_BLANK_EN
        send_exp(200, 128, 128, 1'b0, 0,   0,   0);
`else
        send_exp(200, 128, 128, 1'b0, 200, 200, 200);
`endif
        for (int i = 0; i < 4; i++) send_model(1'b1, 0, 128, 128, 1'b0, 1'b0, 1'b1);

        // random stream with ce gaps
        rand_stream(400);

        // asynchronous reset with a full pipeline
        for (int i = 0; i < 5; i++) send_model(1'b1, $urandom_range(255), $urandom_range(255),
                                               $urandom_range(255), 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1 vif.ce = 1'b0;
        #2 rst_n = 1'b0;
        #1 cmp("async_reset_zero", actual(), '0);
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;

        // first post-reset pixels: zeros until the 4th ce edge, then this pixel
        send_model(1'b1, 255, 255, 0, 1'b1, 1'b0, 1'b1);
        rand_stream(300);

        for (int i = 0; i < 6; i++) send_model(1'b1, 10, 20, 30, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1 vif.ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
